// File: rtl/rst_cond_pkg.sv
// Shared types and helpers for the conditional reset bank.
// Holds the sequencer state encoding and the channel-index width function.
package rst_cond_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Width of an index able to address n channels, never narrower than one bit.
  function automatic int idx_w(input int n);
    if (n <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rst_cond_chan_reg.sv
// One W-bit channel register: hard reset, clear, write and hold.
// Clear beats write so a soft reset is never lost to a concurrent store.
module rst_cond_chan_reg #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_r;

  // Channel storage with priority rst > clr > write > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RESET_VAL;
    end else if (clr) begin
      q_r <= RESET_VAL;
    end else if (wr_en) begin
      q_r <= d;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/rst_cond_reset_bank.sv
// Register bank with a sequenced, mask-selective soft reset (one channel per cycle).
// Optional sticky per-channel clear status when RST_COND_RESET_BANK_STATUS_EN is defined.
module rst_cond_reset_bank
  import rst_cond_pkg::*;
#(
  parameter int           NCH       = 4,
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = {W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   rst_en_mask,
  input  logic             soft_rst_req,
  output logic             soft_rst_ack,
  output logic             busy,
  input  logic [NCH-1:0]   wr_en,
  input  logic [NCH*W-1:0] data_in,
  output logic [NCH*W-1:0] data_out
`ifdef RST_COND_RESET_BANK_STATUS_EN
  ,
  output logic [NCH-1:0]   cleared_sts
`endif
);

  localparam int            IW       = idx_w(NCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 32'sd1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);
  localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};

  state_e         state_r;
  state_e         state_nxt_s;
  logic [IW-1:0]  idx_r;
  logic [IW-1:0]  idx_nxt_s;
  logic [NCH-1:0] mask_r;
  logic [NCH-1:0] mask_nxt_s;
  logic           start_s;
  logic           busy_r;
  logic           ack_r;
  logic [NCH-1:0] clr_s;

  // Sequencer next-state: accept in IDLE, walk channels in SEQ, pulse in ACK.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    mask_nxt_s  = mask_r;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (soft_rst_req) begin
          state_nxt_s = SEQ;
          idx_nxt_s   = IDX_ZERO;
          mask_nxt_s  = rst_en_mask;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEQ: begin
        if (idx_r == LAST_IDX) begin
          state_nxt_s = ACK;
        end else begin
          idx_nxt_s = idx_r + IDX_ONE;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
        idx_nxt_s   = IDX_ZERO;
      end
    endcase
  end

  // Sequencer state plus status outputs registered from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      idx_r   <= IDX_ZERO;
      mask_r  <= {NCH{1'b0}};
      busy_r  <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      mask_r  <= mask_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
      ack_r   <= (state_nxt_s == ACK);
    end
  end

  assign busy         = busy_r;
  assign soft_rst_ack = ack_r;

  genvar c;
  generate
    for (c = 0; c < NCH; c++) begin : g_chan
      assign clr_s[c] = (state_r == SEQ) && (idx_r == IW'(c)) && mask_r[c];

      rst_cond_chan_reg #(
        .W         (W),
        .RESET_VAL (RESET_VAL)
      ) u_chan (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr_s[c]),
        .wr_en (wr_en[c]),
        .d     (data_in[c*W +: W]),
        .q     (data_out[c*W +: W])
      );
    end
  endgenerate

`ifdef RST_COND_RESET_BANK_STATUS_EN
  logic [NCH-1:0] sts_r;

  // Sticky record of which channels the current sequence has cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      sts_r <= {NCH{1'b0}};
    end else if (start_s) begin
      sts_r <= {NCH{1'b0}};
    end else begin
      sts_r <= sts_r | clr_s;
    end
  end

  assign cleared_sts = sts_r;
`endif

endmodule

// File: tb/tb_rst_cond_reset_bank.sv
// Self-checking bench for rst_cond_reset_bank: directed scenarios then random traffic,
// every cycle compared against a channel-level behavioural model.
module tb_rst_cond_reset_bank;

  localparam int           NCH = 4;
  localparam int           W   = 8;
  localparam logic [W-1:0] RV  = 8'h00;

  logic             clk;
  logic             rst;
  logic [NCH-1:0]   rst_en_mask;
  logic             soft_rst_req;
  logic             soft_rst_ack;
  logic             busy;
  logic [NCH-1:0]   wr_en;
  logic [NCH*W-1:0] data_in;
  logic [NCH*W-1:0] data_out;
`ifdef RST_COND_RESET_BANK_STATUS_EN
  logic [NCH-1:0]   cleared_sts;
`endif

  int total;
  int bad;

  // Model: channel contents, position in the sequence (-1 idle, 0..NCH-1 clearing
  // that channel, NCH acking), latched mask and sticky status.
  logic [W-1:0]   m_data [NCH];
  int             m_pos;
  logic [NCH-1:0] m_mask;
  logic [NCH-1:0] m_sts;
  string          phase;

  rst_cond_reset_bank #(.NCH(NCH), .W(W), .RESET_VAL(RV)) dut (
    .clk          (clk),
    .rst          (rst),
    .rst_en_mask  (rst_en_mask),
    .soft_rst_req (soft_rst_req),
    .soft_rst_ack (soft_rst_ack),
    .busy         (busy),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .data_out     (data_out)
`ifdef RST_COND_RESET_BANK_STATUS_EN
    ,
    .cleared_sts  (cleared_sts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [NCH*W-1:0] m_pack();
    logic [NCH*W-1:0] r;
    for (int i = 0; i < NCH; i++) r[i*W +: W] = m_data[i];
    return r;
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NCH; i++) m_data[i] = RV;
      m_pos  = -1;
      m_mask = '0;
      m_sts  = '0;
    end else begin
      for (int i = 0; i < NCH; i++) if (wr_en[i]) m_data[i] = data_in[i*W +: W];
      if (m_pos >= 0 && m_pos < NCH && m_mask[m_pos]) begin
        m_data[m_pos] = RV;
        m_sts[m_pos]  = 1'b1;
      end
      if (m_pos == -1) begin
        if (soft_rst_req) begin
          m_pos  = 0;
          m_mask = rst_en_mask;
          m_sts  = '0;
        end
      end else if (m_pos < NCH) begin
        m_pos++;
      end else begin
        m_pos = -1;
      end
    end
  endtask

  // One clock: model follows the inputs present at the edge, outputs compared 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("data", 64'(data_out), 64'(m_pack()));
    check("busy", 64'(busy), 64'(m_pos != -1));
    check("ack", 64'(soft_rst_ack), 64'(m_pos == NCH));
`ifdef RST_COND_RESET_BANK_STATUS_EN
    check("sts", 64'(cleared_sts), 64'(m_sts));
`endif
  endtask

  task automatic write_all(input logic [NCH*W-1:0] v);
    wr_en   = '1;
    data_in = v;
    cycle();
    wr_en   = '0;
  endtask

  initial begin
    int ack_at [$];
    total = 0;
    bad   = 0;
    for (int i = 0; i < NCH; i++) m_data[i] = 8'h5C;
    m_pos = -1; m_mask = '0; m_sts = '0;
    rst = 1'b1; rst_en_mask = '0; soft_rst_req = 1'b0; wr_en = '0; data_in = '0;

    phase = "por";
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    phase = "hard_rst";
    write_all(32'hAAAA_AAAA);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("all_zero", 64'(data_out), 64'h0);
    check("busy0", 64'(busy), 64'h0);
    check("ack0", 64'(soft_rst_ack), 64'h0);

    // ACK occupies the fifth cycle after the accepting edge, visible right after edge 4.
    phase = "masked";
    write_all(32'h4433_2211);
    rst_en_mask = 4'b0101; soft_rst_req = 1'b1;
    cycle();
    soft_rst_req = 1'b0; rst_en_mask = 4'b1111;
    ack_at.delete();
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (soft_rst_ack) ack_at.push_back(k);
    end
    check("ack_count", 64'(ack_at.size()), 64'd1);
    if (ack_at.size() > 0) check("ack_edge", 64'(ack_at[0]), 64'd4);
    check("result", 64'(data_out), 64'h4400_2200);

    phase = "collision";
    write_all(32'h4433_2211);
    rst_en_mask = 4'b0100; soft_rst_req = 1'b1;
    cycle();
    soft_rst_req = 1'b0;
    cycle(); cycle();
    wr_en = 4'b1100; data_in = 32'h775A_0000;
    cycle();
    wr_en = '0;
    check("ch2", 64'(data_out[2*W +: W]), 64'h00);
    check("ch3", 64'(data_out[3*W +: W]), 64'h77);
    for (int k = 0; k < 4; k++) cycle();

    phase = "abort";
    write_all(32'h4433_2211);
    rst_en_mask = 4'b1111; soft_rst_req = 1'b1;
    cycle();
    soft_rst_req = 1'b0;
    cycle(); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    check("idle", 64'(busy), 64'h0);
    check("zeroed", 64'(data_out), 64'h0);
    ack_at.delete();
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (soft_rst_ack) ack_at.push_back(k);
    end
    check("no_ack", 64'(ack_at.size()), 64'd0);

    phase = "held";
    rst_en_mask = 4'b0011; soft_rst_req = 1'b1;
    ack_at.delete();
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (soft_rst_ack) ack_at.push_back(k);
    end
    soft_rst_req = 1'b0;
    check("acks", 64'(ack_at.size()), 64'd2);
    if (ack_at.size() == 2) begin
      check("ack1", 64'(ack_at[0]), 64'd4);
      check("ack2", 64'(ack_at[1]), 64'd10);
    end
    for (int k = 0; k < 6; k++) cycle();

    phase = "zero_mask";
    write_all(32'hDEAD_BEEF);
    rst_en_mask = 4'b0000; soft_rst_req = 1'b1;
    cycle();
    soft_rst_req = 1'b0;
    ack_at.delete();
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (soft_rst_ack) ack_at.push_back(k);
    end
    check("zm_acks", 64'(ack_at.size()), 64'd1);
    if (ack_at.size() > 0) check("zm_edge", 64'(ack_at[0]), 64'd4);
    check("zm_data", 64'(data_out), 64'hDEAD_BEEF);

`ifdef RST_COND_RESET_BANK_STATUS_EN
    phase = "status";
    rst_en_mask = 4'b1001; soft_rst_req = 1'b1; cycle(); soft_rst_req = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    check("sts1001", 64'(cleared_sts), 64'h9);
    rst_en_mask = 4'b0000; soft_rst_req = 1'b1; cycle(); soft_rst_req = 1'b0;
    for (int k = 0; k < 6; k++) cycle();
    check("sts0000", 64'(cleared_sts), 64'h0);
`endif

    phase = "random";
    for (int n = 0; n < 500; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      soft_rst_req = ($urandom_range(0, 3) == 0);
      rst_en_mask  = NCH'($urandom);
      wr_en        = NCH'($urandom) & NCH'($urandom);
      for (int i = 0; i < NCH; i++) data_in[i*W +: W] = W'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_cond_reset_bank.md
RST_COND_RESET_BANK -- requirements
Module: rst_cond_reset_bank

Interface
REQ-001 Parameter NCH, default 4: number of register channels, range 1..32.
REQ-002 Parameter W, default 8: data width per channel, range 1..64.
REQ-003 Parameter RESET_VAL, default 0: W-bit value loaded into a channel on any reset.
REQ-004 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1: reset, synchronous, active-high; unconditional hard reset of all state.
REQ-006 rst_en_mask  input  NCH: per-channel soft-reset enable, 1 = channel is cleared by a soft reset.
REQ-007 soft_rst_req  input  1: request to start a soft-reset sequence.
REQ-008 soft_rst_ack  output  1: one-cycle pulse marking sequence completion.
REQ-009 busy  output  1: high while a soft-reset sequence is running.
REQ-010 wr_en  input  NCH: per-channel write strobe.
REQ-011 data_in  input  NCH*W: channel c occupies bits [c*W +: W].
REQ-012 data_out  output  NCH*W: registered channel values, same packing as data_in.

Function
REQ-013 FSM states SHALL be IDLE, SEQ, ACK.
REQ-014 In IDLE with soft_rst_req=1, the block SHALL latch rst_en_mask, clear idx to 0, and enter SEQ next cycle.
REQ-015 In SEQ, each cycle SHALL process channel idx: load RESET_VAL if its latched mask bit is 1, else hold; then idx increments.
REQ-016 SEQ SHALL last exactly NCH cycles; when idx=NCH-1 it SHALL go to ACK with no wrap-around beyond NCH-1.
REQ-017 ACK SHALL last one cycle with soft_rst_ack=1, then return to IDLE.
REQ-018 busy SHALL be 1 in SEQ and ACK and 0 in IDLE.
REQ-019 Request-to-ack latency SHALL be NCH+1 cycles after the accepting edge.
REQ-020 soft_rst_req SHALL be ignored in SEQ and ACK; if still high in IDLE after ACK, a new sequence SHALL start.
REQ-021 rst_en_mask changes after latching SHALL not affect the running sequence.
REQ-022 When wr_en[c]=1, data_out channel c SHALL load data_in channel c on the next edge, in every state.
REQ-023 If a write and a clear hit the same channel in the same cycle, the clear SHALL win.
REQ-024 A channel with mask bit 0 SHALL keep its value through the sequence unless written.
REQ-025 A latched mask of all zeros SHALL still run the full NCH+1 cycle sequence and produce the ack.

Reset
REQ-026 rst=1 SHALL set every data_out channel to RESET_VAL regardless of rst_en_mask.
REQ-027 rst=1 SHALL set the FSM to IDLE, idx to 0, busy to 0, soft_rst_ack to 0, and the latched mask to 0.
REQ-028 rst asserted mid-sequence SHALL abort the sequence with no ack pulse; rst SHALL have priority over wr_en and the soft-reset sequence.

Configuration
REQ-029 With macro RST_COND_RESET_BANK_STATUS_EN defined, output cleared_sts (NCH) SHALL be added: a sticky bit per channel, set when the sequence clears that channel, zeroed by rst or by the start of a new sequence.
REQ-030 Without RST_COND_RESET_BANK_STATUS_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package rst_cond_pkg SHALL hold the FSM state enum type and the idx width function ($clog2(NCH) with a minimum of 1).
REQ-032 One sub-module, rst_cond_chan_reg (a W-bit register with write, clear, and hold), SHALL be instantiated NCH times.

Verification
REQ-033 Hard reset: set all channels to 0xAA, assert rst for one cycle -> all channels read 0x00, busy=0, ack=0.
REQ-034 Masked sequence: channels 0..3 = 0x11,0x22,0x33,0x44, mask=4'b0101, req one cycle -> channels 0x00,0x22,0x00,0x44, ack high exactly 5 cycles after the accepting edge.
REQ-035 Collision: during SEQ with idx=2 and mask bit 2=1, wr_en[2]=1 with 0x5A -> channel 2=0x00; a concurrent write of 0x77 to unmasked channel 3 -> channel 3=0x77.
REQ-036 Mid-sequence abort: rst at SEQ cycle 2 -> IDLE next cycle, no ack pulse, all channels 0x00.
REQ-037 Held request: soft_rst_req held high for 12 cycles -> two back-to-back sequences, ack at cycles 5 and 11 after the first accepting edge.
REQ-038 Status (macro on): mask=4'b1001 -> cleared_sts=4'b1001 after ack; a second request with mask=0 -> cleared_sts=4'b0000.
